jtag_dtm_ext: RTL and testbench
===============================

// Module: jtag_dtm_ext
// PURPOSE
//  Parametrised RISC-V Debug Transport Module, the successor to jtag_dtm. Sits behind jtag_tap_controller and bridges DTMCS/DMI DR scans to a DMI req/ack bus.
//  Adds configurable address width, a sticky busy/failed status, dmireset/dmihardreset, and a DMI ack timeout.
//  Supports one outstanding DMI operation.
// PARAMETERS
//  ABITS       7      DMI address width (1..32); reported in DTMCS.abits
//  IDLE_HINT   1      DTMCS.idle value (0..7)
//  TIMEOUT     1023   tck cycles to wait for dmi_ack before abort; 0 = wait forever
//  IR_DTMCS    5'h10  IR code selecting DTMCS
//  IR_DMI      5'h11  IR code selecting DMI
// PORTS
//  tck            in   1          JTAG clock; all state changes on posedge
//  trst_n         in   1          async active-low reset
//  ir_value       in   5          current TAP instruction
//  dr_capture     in   1          TAP Capture-DR strobe
//  dr_shift       in   1          TAP Shift-DR strobe
//  dr_update      in   1          TAP Update-DR strobe
//  tdi            in   1          serial data in
//  tdo            out  1          serial data out; bit 0 of the selected shift register, 0 when not selected
//  dmi_addr       out  ABITS      DMI address
//  dmi_wdata      out  32         DMI write data
//  dmi_op         out  2          1=read, 2=write
//  dmi_req        out  1          request; level, held until ack
//  dmi_rdata      in   32         read data; valid with dmi_ack
//  dmi_resp       in   2          0=ok, 2=failed, 3=busy; valid with dmi_ack
//  dmi_ack        in   1          one-cycle completion pulse
//  dmi_busy       out  1          operation outstanding (= FSM in REQ)
//  dmi_sticky     out  2          current dmistat
// BEHAVIOUR
//  Reset: all outputs 0; shift regs, dmistat, rdata latch and timeout counter cleared; FSM=IDLE. Reset is async and aborts an in-flight request, dropping dmi_req immediately.
//  DTMCS capture (32b): {14'b0, 2'b0 (hardreset/reset read 0), 1'b0, IDLE_HINT[2:0], dmistat[1:0], ABITS[5:0], 4'd1}.
//  DTMCS update: bit16=1 clears dmistat. bit17=1 aborts the FSM to IDLE, drops dmi_req, clears dmistat and the counter. Other bits ignored.
//  DMI DR width W=ABITS+34, laid out {addr, data[31:0], op[1:0]}. Shift is LSB first: sr <= {tdi, sr[W-1:1]}.
//  DMI capture: {last_addr, rdata_latch, dmistat}. If FSM=REQ at capture, dmistat becomes 3 (sticky) and 3 is captured.
//  DMI update, op in {1,2}:
//   FSM=IDLE and dmistat=0: latch addr/data/op; dmi_req=1 from the next posedge; FSM->REQ.
//   FSM=REQ: dmistat becomes 3 and the request is dropped.
//   dmistat!=0: ignored.
//  DMI update, op in {0,3}: no operation.
//  FSM IDLE->REQ on an accepted update. REQ->IDLE on dmi_ack, timeout or hardreset.
//  On dmi_ack, dmi_req deasserts at the same edge (combinational req = state==REQ).
//   op=read: rdata_latch <= dmi_rdata.
//   dmi_resp=2: dmistat 2. dmi_resp=3: dmistat 3. Both only if dmistat was 0; first error wins.
//  Timeout: counter runs in REQ; reaching TIMEOUT gives dmistat=2 (if 0), dmi_req drop, FSM->IDLE. A late ack in IDLE is ignored.
//  Simultaneous events:
//   ack + update in the same cycle: ack is processed first, then the update sees IDLE.
//   hardreset + ack: hardreset wins.
//  dmi_addr/wdata/op are held stable while dmi_req=1.
//  Latency: update edge -> req next posedge. The result is visible at the next DMI capture.
// STRUCTURE
//  Shared include jtag_dtm_defs.vh: DMI op codes, dmistat codes (OK/FAILED/BUSY), IR codes, FSM state encodings. Shared with the debug module.
//  One sub-module, dtm_shift_reg #(W): capture/shift/tdo logic, instanced for DTMCS (W=32) and DMI (W=ABITS+34).
//  Top level holds the FSM, dmistat, timeout counter and rdata latch.
// TESTING
//  1 Reset, DTMCS read with ABITS=7, IDLE_HINT=1 -> 0x00001071.
//  2 Read addr 0x10, mock acks 1 cycle later with 0xDEAD0010/resp 0; nop scan -> data 0xDEAD0010, op field 0.
//  3 Write 0x20=0xCAFEBABE, read back -> 0xCAFEBABE. Repeat with ABITS=12, addr 0xABC -> same data.
//  4 Mock withholds ack, second DMI scan issued -> captured op 3, dmistat=3, no new req. DTMCS write 0x10000 -> dmistat 0. Ack then returns and the next read succeeds.
//  5 TIMEOUT=16, mock never acks -> req drops after 16 cycles, dmistat=2, and a later ack is ignored.
//  6 Assert trst_n low while dmi_req=1 -> req 0 with no tck edge; DTMCS reads 0x00001071 again.

Source files
------------

// File: rtl/jtag_dtm_ext_pkg.sv
// Shared definitions for the extended JTAG debug transport module:
// DMI op codes, dmistat codes, default IR codes, FSM state encoding and
// the DTMCS capture word builder.
package jtag_dtm_ext_pkg;

    localparam int unsigned DMI_DATA_W = 32;
    localparam int unsigned DMI_OP_W   = 2;
    localparam int unsigned DMISTAT_W  = 2;
    localparam int unsigned IR_W       = 5;
    localparam int unsigned DTMCS_W    = 32;

    localparam logic [DMI_OP_W-1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [DMI_OP_W-1:0] DMI_OP_READ  = 2'd1;
    localparam logic [DMI_OP_W-1:0] DMI_OP_WRITE = 2'd2;

    localparam logic [DMISTAT_W-1:0] DMISTAT_OK     = 2'd0;
    localparam logic [DMISTAT_W-1:0] DMISTAT_FAILED = 2'd2;
    localparam logic [DMISTAT_W-1:0] DMISTAT_BUSY   = 2'd3;

    localparam logic [IR_W-1:0] IR_DTMCS_DEF = 5'h10;
    localparam logic [IR_W-1:0] IR_DMI_DEF   = 5'h11;

    localparam int unsigned DTMCS_DMIRESET_BIT  = 16;
    localparam int unsigned DTMCS_HARDRESET_BIT = 17;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } dtm_state_e;

    // DTMCS read value; dmireset/dmihardreset always read back as 0.
    function automatic logic [DTMCS_W-1:0] dtmcs_word(
        input logic [2:0]           idle,
        input logic [DMISTAT_W-1:0] stat,
        input logic [5:0]           abits
    );
        return {14'b0, 2'b0, 1'b0, idle, stat, abits, 4'd1};
    endfunction

endpackage

// File: rtl/jtag_dtm_ext_if.sv
// DMI request/acknowledge bus between the DTM (master) and the debug
// module (slave).
//   addr/wdata/op/req : master -> slave, request payload held while req=1
//   rdata/resp/ack    : slave -> master, valid with the one-cycle ack pulse
interface jtag_dtm_ext_if #(
    parameter int unsigned ABITS = 7
);
    import jtag_dtm_ext_pkg::*;

    logic [ABITS-1:0]      addr;
    logic [DMI_DATA_W-1:0] wdata;
    logic [DMI_OP_W-1:0]   op;
    logic                  req;
    logic [DMI_DATA_W-1:0] rdata;
    logic [DMISTAT_W-1:0]  resp;
    logic                  ack;

    modport master (
        output addr, wdata, op, req,
        input  rdata, resp, ack
    );

    modport slave (
        input  addr, wdata, op, req,
        output rdata, resp, ack
    );

endinterface

// File: rtl/jtag_dtm_ext_shift_reg.sv
// Capture/shift data register used for both DTMCS and DMI.
//   tck, trst_n      : JTAG clock, async active-low reset
//   sel_i            : this register is selected by the current IR
//   capture_i        : Capture-DR strobe, loads capture_data_i
//   shift_i, tdi_i   : Shift-DR strobe and serial input (LSB first)
//   data_o           : parallel register contents, read at Update-DR
//   tdo_o            : bit 0 when selected, else 0
module jtag_dtm_ext_shift_reg #(
    parameter int unsigned W = 32
) (
    input  logic         tck,
    input  logic         trst_n,
    input  logic         sel_i,
    input  logic         capture_i,
    input  logic         shift_i,
    input  logic         tdi_i,
    input  logic [W-1:0] capture_data_i,
    output logic [W-1:0] data_o,
    output logic         tdo_o
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    // Capture has priority; the TAP never asserts both strobes together.
    always_comb begin : sr_next
        sr_d = sr_q;
        if (sel_i && capture_i) begin
            sr_d = capture_data_i;
        end else if (sel_i && shift_i) begin
            sr_d = {tdi_i, sr_q[W-1:1]};
        end
    end

    always_ff @(posedge tck or negedge trst_n) begin : sr_reg
        if (!trst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign data_o = sr_q;
    assign tdo_o  = sel_i & sr_q[0];

endmodule

// File: rtl/jtag_dtm_ext.sv
// RISC-V debug transport module: bridges DTMCS/DMI DR scans from the TAP
// to a single-outstanding DMI req/ack bus, with sticky dmistat, dmireset,
// dmihardreset and an optional ack timeout.
//   tck, trst_n            : JTAG clock, async active-low reset
//   ir_value               : current TAP instruction
//   dr_capture/shift/update: TAP DR strobes
//   tdi, tdo               : serial data in/out
//   dmi                    : DMI bus (master side)
//   dmi_busy               : operation outstanding
//   dmi_sticky             : current dmistat
module jtag_dtm_ext
    import jtag_dtm_ext_pkg::*;
#(
    parameter int unsigned    ABITS     = 7,
    parameter int unsigned    IDLE_HINT = 1,
    parameter int unsigned    TIMEOUT   = 1023,
    parameter logic [IR_W-1:0] IR_DTMCS = IR_DTMCS_DEF,
    parameter logic [IR_W-1:0] IR_DMI   = IR_DMI_DEF
) (
    input  logic                  tck,
    input  logic                  trst_n,
    input  logic [IR_W-1:0]       ir_value,
    input  logic                  dr_capture,
    input  logic                  dr_shift,
    input  logic                  dr_update,
    input  logic                  tdi,
    output logic                  tdo,
    jtag_dtm_ext_if.master        dmi,
    output logic                  dmi_busy,
    output logic [DMISTAT_W-1:0]  dmi_sticky
);

    localparam int unsigned DMI_W   = ABITS + DMI_DATA_W + DMI_OP_W;
    localparam int unsigned CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    dtm_state_e state_q, state_d;

    logic [DMISTAT_W-1:0]  stat_q, stat_d, stat_mid;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ABITS-1:0]      addr_q, addr_d;
    logic [DMI_DATA_W-1:0] wdata_q, wdata_d;
    logic [DMI_OP_W-1:0]   op_q, op_d;
    logic [DMI_DATA_W-1:0] rdata_q, rdata_d;

    // ---------------------------------------------------------------
    // Data registers
    // ---------------------------------------------------------------
    logic                  sel_dtmcs, sel_dmi;
    logic [DTMCS_W-1:0]    dtmcs_cap, dtmcs_sr;
    logic [DMI_W-1:0]      dmi_cap, dmi_sr;
    logic [DMISTAT_W-1:0]  cap_stat;
    logic                  dtmcs_tdo, dmi_tdo;

    assign sel_dtmcs = (ir_value == IR_DTMCS);
    assign sel_dmi   = (ir_value == IR_DMI);

    assign dtmcs_cap = dtmcs_word(3'(IDLE_HINT), stat_q, 6'(ABITS));

    // A capture while an operation is still outstanding reports busy.
    assign cap_stat = (state_q == ST_REQ) ? DMISTAT_BUSY : stat_q;
    assign dmi_cap  = {addr_q, rdata_q, cap_stat};

    jtag_dtm_ext_shift_reg #(.W(DTMCS_W)) u_dtmcs_sr (
        .tck            (tck),
        .trst_n         (trst_n),
        .sel_i          (sel_dtmcs),
        .capture_i      (dr_capture),
        .shift_i        (dr_shift),
        .tdi_i          (tdi),
        .capture_data_i (dtmcs_cap),
        .data_o         (dtmcs_sr),
        .tdo_o          (dtmcs_tdo)
    );

    jtag_dtm_ext_shift_reg #(.W(DMI_W)) u_dmi_sr (
        .tck            (tck),
        .trst_n         (trst_n),
        .sel_i          (sel_dmi),
        .capture_i      (dr_capture),
        .shift_i        (dr_shift),
        .tdi_i          (tdi),
        .capture_data_i (dmi_cap),
        .data_o         (dmi_sr),
        .tdo_o          (dmi_tdo)
    );

    // IR codes are distinct, so at most one term is non-zero.
    assign tdo = dtmcs_tdo | dmi_tdo;

    // Only the reset control bits of DTMCS are writable.
    logic unused_dtmcs_bits;
    assign unused_dtmcs_bits = ^{dtmcs_sr[DTMCS_W-1:DTMCS_HARDRESET_BIT+1],
                                 dtmcs_sr[DTMCS_DMIRESET_BIT-1:0]};

    // ---------------------------------------------------------------
    // Events
    // ---------------------------------------------------------------
    logic                  hardreset, dmireset;
    logic                  dmi_upd, dmi_cap_evt, op_valid;
    logic                  ack_evt, timeout_evt, done_evt;
    logic                  accept, clash;
    logic [ABITS-1:0]      upd_addr;
    logic [DMI_DATA_W-1:0] upd_data;
    logic [DMI_OP_W-1:0]   upd_op;

    assign upd_addr = dmi_sr[DMI_W-1 -: ABITS];
    assign upd_data = dmi_sr[DMI_OP_W +: DMI_DATA_W];
    assign upd_op   = dmi_sr[DMI_OP_W-1:0];

    assign hardreset   = dr_update && sel_dtmcs && dtmcs_sr[DTMCS_HARDRESET_BIT];
    assign dmireset    = dr_update && sel_dtmcs && dtmcs_sr[DTMCS_DMIRESET_BIT];
    assign dmi_upd     = dr_update && sel_dmi;
    assign dmi_cap_evt = dr_capture && sel_dmi;
    assign op_valid    = (upd_op == DMI_OP_READ) || (upd_op == DMI_OP_WRITE);

    // Hardreset overrides a coincident ack; ack overrides a coincident timeout.
    assign ack_evt     = (state_q == ST_REQ) && dmi.ack && !hardreset;
    assign timeout_evt = (TIMEOUT != 0) && (state_q == ST_REQ) && !dmi.ack &&
                         !hardreset && (cnt_q == CNT_W'(TO_LAST));
    assign done_evt    = ack_evt || timeout_evt;

    // Completion is applied before a same-cycle update, so the update
    // sees the post-completion state and dmistat.
    always_comb begin : stat_after_done
        stat_mid = stat_q;
        if (stat_q == DMISTAT_OK) begin
            if (ack_evt && (dmi.resp == DMISTAT_FAILED || dmi.resp == DMISTAT_BUSY)) begin
                stat_mid = dmi.resp;
            end else if (timeout_evt) begin
                stat_mid = DMISTAT_FAILED;
            end
        end
    end

    assign accept = dmi_upd && op_valid && !hardreset &&
                    ((state_q == ST_IDLE) || done_evt) && (stat_mid == DMISTAT_OK);
    assign clash  = dmi_upd && op_valid && (state_q == ST_REQ) && !done_evt;

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge tck or negedge trst_n) begin : fsm_reg
        if (!trst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : fsm_next
        state_d = state_q;
        if (hardreset) begin
            state_d = ST_IDLE;
        end else if (accept) begin
            state_d = ST_REQ;
        end else if (done_evt || clash) begin
            state_d = ST_IDLE;
        end
    end

    // Request is a function of state so reset and completion drop it at once.
    always_comb begin : fsm_out
        dmi.req  = 1'b0;
        dmi_busy = 1'b0;
        if (state_q == ST_REQ) begin
            dmi.req  = 1'b1;
            dmi_busy = 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Datapath: dmistat, timeout counter, request payload, read data
    // ---------------------------------------------------------------
    always_comb begin : dp_next
        stat_d  = stat_mid;
        cnt_d   = '0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        rdata_d = rdata_q;

        if (dmi_cap_evt && (state_q == ST_REQ)) begin
            stat_d = DMISTAT_BUSY;
        end
        if (clash) begin
            stat_d = DMISTAT_BUSY;
        end
        if (dmireset || hardreset) begin
            stat_d = DMISTAT_OK;
        end

        if ((state_q == ST_REQ) && !done_evt && !clash && !hardreset) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (ack_evt && (op_q == DMI_OP_READ)) begin
            rdata_d = dmi.rdata;
        end

        if (accept) begin
            addr_d  = upd_addr;
            wdata_d = upd_data;
            op_d    = upd_op;
        end
    end

    always_ff @(posedge tck or negedge trst_n) begin : dp_reg
        if (!trst_n) begin
            stat_q  <= DMISTAT_OK;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= DMI_OP_NOP;
            rdata_q <= '0;
        end else begin
            stat_q  <= stat_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            rdata_q <= rdata_d;
        end
    end

    assign dmi.addr   = addr_q;
    assign dmi.wdata  = wdata_q;
    assign dmi.op     = op_q;
    assign dmi_sticky = stat_q;

endmodule

// File: tb/tb_jtag_dtm_ext.sv
// Directed bench for jtag_dtm_ext: dut0 uses ABITS=7/TIMEOUT=1023,
// dut1 uses ABITS=12/TIMEOUT=16. Each has its own TAP stimulus and a
// DMI mock that either acks one cycle after req or withholds the ack.
module tb_jtag_dtm_ext;

    logic tck = 1'b0;
    always #5 tck = ~tck;

    logic       trst_n;
    logic [4:0] ir_v   [2];
    logic       cap_v  [2];
    logic       sh_v   [2];
    logic       upd_v  [2];
    logic       tdi_v  [2];
    logic       mode_v [2];   // 0 = auto ack, 1 = withhold
    logic       pulse_v[2];   // force a one-cycle ack
    logic [1:0] resp_v [2];

    logic       tdo0, tdo1, busy0, busy1;
    logic [1:0] sticky0, sticky1;

    jtag_dtm_ext_if #(.ABITS(7))  dmi0 ();
    jtag_dtm_ext_if #(.ABITS(12)) dmi1 ();

    jtag_dtm_ext #(.ABITS(7), .IDLE_HINT(1), .TIMEOUT(1023),
                   .IR_DTMCS(5'h10), .IR_DMI(5'h11)) u_dut0 (
        .tck(tck), .trst_n(trst_n), .ir_value(ir_v[0]),
        .dr_capture(cap_v[0]), .dr_shift(sh_v[0]), .dr_update(upd_v[0]),
        .tdi(tdi_v[0]), .tdo(tdo0), .dmi(dmi0),
        .dmi_busy(busy0), .dmi_sticky(sticky0)
    );

    jtag_dtm_ext #(.ABITS(12), .IDLE_HINT(1), .TIMEOUT(16),
                   .IR_DTMCS(5'h10), .IR_DMI(5'h11)) u_dut1 (
        .tck(tck), .trst_n(trst_n), .ir_value(ir_v[1]),
        .dr_capture(cap_v[1]), .dr_shift(sh_v[1]), .dr_update(upd_v[1]),
        .tdi(tdi_v[1]), .tdo(tdo1), .dmi(dmi1),
        .dmi_busy(busy1), .dmi_sticky(sticky1)
    );

    // DMI mocks: memory per DUT, unwritten reads return 0xDEAD0000|addr
    logic [31:0] mem0 [logic [31:0]];
    logic [31:0] mem1 [logic [31:0]];

    always @(posedge tck) begin : mock0
        logic [31:0] a;
        a = 32'(dmi0.addr);
        if (!trst_n) begin
            dmi0.ack <= 1'b0; dmi0.resp <= 2'd0; dmi0.rdata <= 32'd0;
        end else if ((!mode_v[0] && dmi0.req && !dmi0.ack) || pulse_v[0]) begin
            dmi0.ack   <= 1'b1;
            dmi0.resp  <= resp_v[0];
            dmi0.rdata <= mem0.exists(a) ? mem0[a] : (32'hDEAD0000 | {16'h0, a[15:0]});
            if (dmi0.req && dmi0.op == 2'd2 && resp_v[0] == 2'd0) mem0[a] = dmi0.wdata;
        end else begin
            dmi0.ack <= 1'b0;
        end
    end

    always @(posedge tck) begin : mock1
        logic [31:0] a;
        a = 32'(dmi1.addr);
        if (!trst_n) begin
            dmi1.ack <= 1'b0; dmi1.resp <= 2'd0; dmi1.rdata <= 32'd0;
        end else if ((!mode_v[1] && dmi1.req && !dmi1.ack) || pulse_v[1]) begin
            dmi1.ack   <= 1'b1;
            dmi1.resp  <= resp_v[1];
            dmi1.rdata <= mem1.exists(a) ? mem1[a] : (32'hDEAD0000 | {16'h0, a[15:0]});
            if (dmi1.req && dmi1.op == 2'd2 && resp_v[1] == 2'd0) mem1[a] = dmi1.wdata;
        end else begin
            dmi1.ack <= 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic get_tdo(input int d);
        return (d == 0) ? tdo0 : tdo1;
    endfunction

    function automatic logic get_req(input int d);
        return (d == 0) ? dmi0.req : dmi1.req;
    endfunction

    function automatic logic [1:0] get_sticky(input int d);
        return (d == 0) ? sticky0 : sticky1;
    endfunction

    task automatic scan(input int d, input logic [4:0] ir, input int w,
                        input logic [63:0] din, output logic [63:0] dout);
        dout = '0;
        @(negedge tck); ir_v[d] = ir; cap_v[d] = 1'b1;
        @(negedge tck); cap_v[d] = 1'b0; sh_v[d] = 1'b1;
        for (int i = 0; i < w; i++) begin
            tdi_v[d] = din[i];
            dout[i]  = get_tdo(d);
            @(negedge tck);
        end
        sh_v[d] = 1'b0; upd_v[d] = 1'b1;
        @(negedge tck); upd_v[d] = 1'b0; ir_v[d] = 5'h01;
    endtask

    task automatic dtmcs(input int d, input logic [31:0] din, output logic [63:0] dout);
        scan(d, 5'h10, 32, 64'(din), dout);
    endtask

    task automatic dmi_scan(input int d, input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] op, output logic [63:0] dout);
        int ab;
        logic [63:0] v;
        ab = (d == 0) ? 7 : 12;
        v  = {30'b0, data, op} | (64'(addr) << 34);
        scan(d, 5'h11, ab + 34, v, dout);
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (get_req(d) && n < 50) begin
            @(negedge tck);
            n++;
        end
        check($sformatf("idle%0d", d), 64'(get_req(d)), 64'd0);
    endtask

    task automatic pulse_ack(input int d);
        @(negedge tck); pulse_v[d] = 1'b1;
        @(negedge tck); pulse_v[d] = 1'b0;
        @(negedge tck);
    endtask

    logic [63:0] r;
    int          cnt;

    initial begin
        trst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            ir_v[d] = 5'h01; cap_v[d] = 0; sh_v[d] = 0; upd_v[d] = 0; tdi_v[d] = 0;
            mode_v[d] = 0; pulse_v[d] = 0; resp_v[d] = 2'd0;
        end
        repeat (2) @(negedge tck);
        check("rst_req0",  64'(dmi0.req), 64'd0);
        check("rst_tdo0",  64'(tdo0),     64'd0);
        check("rst_stk0",  64'(sticky0),  64'd0);
        check("rst_addr0", 64'(dmi0.addr), 64'd0);
        check("rst_req1",  64'(dmi1.req), 64'd0);
        trst_n = 1'b1;

        // 1: DTMCS readout
        dtmcs(0, 32'h0, r);  check("dtmcs0", r, 64'h1071);
        dtmcs(1, 32'h0, r);  check("dtmcs1", r, 64'h10C1);

        // 2: read 0x10, result seen on the following nop scan
        dmi_scan(0, 32'h10, 32'h0, 2'd1, r);
        check("rd_req",  64'(dmi0.req),  64'd1);
        check("rd_addr", 64'(dmi0.addr), 64'h10);
        check("rd_op",   64'(dmi0.op),   64'd1);
        wait_idle(0);
        dmi_scan(0, 32'h0, 32'h0, 2'd0, r);
        check("rd_data", 64'(r[33:2]), 64'hDEAD0010);
        check("rd_stat", 64'(r[1:0]),  64'd0);
        check("rd_cadr", r >> 34,      64'h10);

        // 3: write then read back, both address widths
        dmi_scan(0, 32'h20, 32'hCAFEBABE, 2'd2, r);
        check("wr_wdata", 64'(dmi0.wdata), 64'hCAFEBABE);
        wait_idle(0);
        dmi_scan(0, 32'h20, 32'h0, 2'd1, r);
        wait_idle(0);
        dmi_scan(0, 32'h0, 32'h0, 2'd0, r);
        check("wrrd0", 64'(r[33:2]), 64'hCAFEBABE);
        dmi_scan(1, 32'hABC, 32'hCAFEBABE, 2'd2, r);
        check("wr_addr1", 64'(dmi1.addr), 64'hABC);
        wait_idle(1);
        dmi_scan(1, 32'hABC, 32'h0, 2'd1, r);
        wait_idle(1);
        dmi_scan(1, 32'h0, 32'h0, 2'd0, r);
        check("wrrd1",  64'(r[33:2]), 64'hCAFEBABE);
        check("cadr1",  r >> 34,      64'hABC);

        // 4: overlapping scan while busy, dmireset, late ack ignored
        mode_v[0] = 1'b1;
        dmi_scan(0, 32'h10, 32'h0, 2'd1, r);
        check("bz_req", 64'(dmi0.req), 64'd1);
        dmi_scan(0, 32'h20, 32'h0, 2'd1, r);
        check("bz_cap",   64'(r[1:0]),    64'd3);
        check("bz_req2",  64'(dmi0.req),  64'd0);
        check("bz_stk",   64'(sticky0),   64'd3);
        check("bz_addr",  64'(dmi0.addr), 64'h10);
        dtmcs(0, 32'h10000, r);
        check("bz_dtmcs", r,              64'h1C71);
        check("bz_clr",   64'(sticky0),   64'd0);
        pulse_ack(0);
        check("late_stk", 64'(sticky0),   64'd0);
        check("late_req", 64'(dmi0.req),  64'd0);
        mode_v[0] = 1'b0;
        dmi_scan(0, 32'h20, 32'h0, 2'd1, r);
        wait_idle(0);
        dmi_scan(0, 32'h0, 32'h0, 2'd0, r);
        check("bz_rd",  64'(r[33:2]), 64'hCAFEBABE);
        check("bz_rs",  64'(r[1:0]),  64'd0);

        // failed response is sticky and blocks further requests
        resp_v[0] = 2'd2;
        dmi_scan(0, 32'h40, 32'h0, 2'd1, r);
        wait_idle(0);
        check("fl_stk", 64'(sticky0), 64'd2);
        resp_v[0] = 2'd0;
        dmi_scan(0, 32'h40, 32'h0, 2'd1, r);
        check("fl_cap", 64'(r[1:0]),   64'd2);
        check("fl_req", 64'(dmi0.req), 64'd0);
        dtmcs(0, 32'h10000, r);
        check("fl_clr", 64'(sticky0),  64'd0);

        // hardreset aborts an outstanding request
        mode_v[0] = 1'b1;
        dmi_scan(0, 32'h30, 32'h0, 2'd1, r);
        check("hr_req0", 64'(dmi0.req), 64'd1);
        dtmcs(0, 32'h20000, r);
        check("hr_req",  64'(dmi0.req), 64'd0);
        check("hr_stk",  64'(sticky0),  64'd0);

        // 5: timeout after 16 cycles on dut1, late ack ignored
        mode_v[1] = 1'b1;
        dmi_scan(1, 32'h5, 32'h0, 2'd1, r);
        cnt = 0;
        while (get_req(1) && cnt < 100) begin
            cnt++;
            @(negedge tck);
        end
        check("to_cycles", 64'(cnt), 64'd16);
        check("to_stk",    64'(get_sticky(1)), 64'd2);
        resp_v[1] = 2'd3;
        pulse_ack(1);
        check("to_late", 64'(sticky1), 64'd2);
        dtmcs(1, 32'h10000, r);
        check("to_dtmcs", r, 64'h18C1);
        check("to_clr", 64'(sticky1), 64'd0);

        // 6: async reset drops req with no clock edge
        dmi_scan(0, 32'h10, 32'h0, 2'd1, r);
        check("ar_req0", 64'(dmi0.req), 64'd1);
        #2 trst_n = 1'b0;
        #1;
        check("ar_req",  64'(dmi0.req), 64'd0);
        check("ar_busy", 64'(busy0),    64'd0);
        #1 trst_n = 1'b1;
        mode_v[0] = 1'b0;
        dtmcs(0, 32'h0, r);
        check("ar_dtmcs", r, 64'h1071);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
